// File: rtl/fir_xifu_ex.sv
// Execute stage of the FIR XIF coprocessor: memory request issue for XFIRLW/XFIRSW
// with autoincrement address, two-cycle signed 4x8-bit dot-product-accumulate for
// XFIRDOTP, and a registered completion record towards writeback.

package cv32e40x_pkg;
    localparam int X_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } privlvl_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           addr;
        privlvl_t              mode;
        logic                  we;
        logic [2:0]            size;
        logic [3:0]            be;
        logic [1:0]            attr;
        logic [31:0]           wdata;
        logic                  last;
        logic                  spec;
    } x_mem_req_t;
endpackage

package fir_xifu_pkg;
    import cv32e40x_pkg::*;

    localparam logic [2:0] INSTR_INVALID  = 3'd0;
    localparam logic [2:0] INSTR_XFIRLW   = 3'd1;
    localparam logic [2:0] INSTR_XFIRSW   = 3'd2;
    localparam logic [2:0] INSTR_XFIRDOTP = 3'd3;

    typedef struct packed {
        logic                  valid;
        logic [2:0]            instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rs1;
        logic [4:0]            rd;
        logic [31:0]           op_a;
        logic [31:0]           op_b;
        logic [31:0]           op_c;
        logic [11:0]           imm;
    } fir_xifu_id2ex_t;

    typedef struct packed {
        logic                  valid;
        logic [2:0]            instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rs1;
        logic [4:0]            rd;
        logic [31:0]           result;
    } fir_xifu_ex2wb_t;
endpackage

// Memory request channel of the coprocessor side of CV-X-IF.
interface cv32e40x_if_xif;
    import cv32e40x_pkg::*;
    logic       mem_valid;
    logic       mem_ready;
    x_mem_req_t mem_req;

    modport coproc_mem (
        output mem_valid,
        output mem_req,
        input  mem_ready
    );
endinterface

module fir_xifu_ex
    import cv32e40x_pkg::*;
    import fir_xifu_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  fir_xifu_id2ex_t           id2ex_i,
    output logic                      ready_o,
    cv32e40x_if_xif.coproc_mem        xif_mem_o,
    input  logic                      kill_i,
    output fir_xifu_ex2wb_t           ex2wb_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DOTP = 2'd2
    } state_e;

    // Only the fields needed after the accept cycle are kept.
    typedef struct packed {
        logic [2:0]            instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rs1;
        logic [4:0]            rd;
        logic [31:0]           op_a;
        logic [31:0]           op_c;
        logic [11:0]           imm;
    } instr_reg_t;

    state_e          state_q, state_d;
    logic            mem_valid_q, mem_valid_d;
    x_mem_req_t      mem_req_q, mem_req_d;
    logic            killed_q, killed_d;
    fir_xifu_ex2wb_t ex2wb_q, ex2wb_d;
    instr_reg_t      instr_q;
    logic signed [15:0] prod_d [4];
    logic signed [15:0] prod_q [4];

    logic accept;
    logic is_mem_op;
    logic kill_now;

    function automatic logic signed [15:0] mul_s8(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] a_ext;
        logic signed [15:0] b_ext;
        a_ext = {{8{a[7]}}, a};
        b_ext = {{8{b[7]}}, b};
        // |a*b| <= 2^14, so the 16-bit product never overflows.
        return a_ext * b_ext;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] p);
        return {{16{p[15]}}, p};
    endfunction

    function automatic logic [31:0] dotp_acc(input logic [31:0] acc,
                                             input logic signed [15:0] p0,
                                             input logic signed [15:0] p1,
                                             input logic signed [15:0] p2,
                                             input logic signed [15:0] p3);
        return acc + sext16(p0) + sext16(p1) + sext16(p2) + sext16(p3);
    endfunction

    function automatic logic [31:0] addr_inc(input logic [31:0] base, input logic [11:0] imm);
        return base + {{20{imm[11]}}, imm};
    endfunction

    function automatic x_mem_req_t build_req(input fir_xifu_id2ex_t d);
        x_mem_req_t r;
        r       = '0;
        r.id    = d.id;
        r.addr  = d.op_a;
        r.mode  = PRIV_LVL_M;
        r.we    = (d.instr == INSTR_XFIRSW);
        r.size  = 3'b010;
        r.be    = 4'hF;
        r.last  = 1'b1;
        r.spec  = 1'b0;
        r.wdata = (d.instr == INSTR_XFIRSW) ? d.op_b : 32'h0;
        return r;
    endfunction

    function automatic fir_xifu_ex2wb_t complete(input logic [2:0] instr,
                                                 input logic [X_ID_WIDTH-1:0] id,
                                                 input logic [4:0] rs1,
                                                 input logic [4:0] rd,
                                                 input logic [31:0] result);
        fir_xifu_ex2wb_t w;
        w.valid  = 1'b1;
        w.instr  = instr;
        w.id     = id;
        w.rs1    = rs1;
        w.rd     = rd;
        w.result = result;
        return w;
    endfunction

    assign ready_o   = (state_q == IDLE);
    assign accept    = id2ex_i.valid & ready_o;
    assign is_mem_op = (id2ex_i.instr == INSTR_XFIRLW) || (id2ex_i.instr == INSTR_XFIRSW);
    // A kill arriving in the completion cycle itself must still suppress writeback.
    assign kill_now  = killed_q | kill_i;

    assign xif_mem_o.mem_valid = mem_valid_q;
    assign xif_mem_o.mem_req   = mem_req_q;
    assign ex2wb_o             = ex2wb_q;

    // First dot-product cycle: four signed byte products straight from the operands.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod_d[i] = mul_s8(id2ex_i.op_a[8*i +: 8], id2ex_i.op_b[8*i +: 8]);
        end
    end

    // Next-state, memory request and completion record.
    always_comb begin
        state_d       = state_q;
        mem_valid_d   = mem_valid_q;
        mem_req_d     = mem_req_q;
        killed_d      = killed_q;
        ex2wb_d       = ex2wb_q;
        ex2wb_d.valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    killed_d = 1'b0;
                    if (is_mem_op) begin
                        state_d     = MEM;
                        mem_valid_d = 1'b1;
                        mem_req_d   = build_req(id2ex_i);
                    end else if (id2ex_i.instr == INSTR_XFIRDOTP) begin
                        state_d = DOTP;
                    end else begin
                        ex2wb_d = complete(id2ex_i.instr, id2ex_i.id, id2ex_i.rs1,
                                           id2ex_i.rd, 32'h0);
                    end
                end
            end
            MEM: begin
                if (kill_i) begin
                    killed_d = 1'b1;
                end
                // The request is never retracted, even when killed.
                if (mem_valid_q && xif_mem_o.mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    if (!kill_now) begin
                        ex2wb_d = complete(instr_q.instr, instr_q.id, instr_q.rs1, instr_q.rd,
                                           addr_inc(instr_q.op_a, instr_q.imm));
                    end
                end
            end
            DOTP: begin
                if (kill_i) begin
                    killed_d = 1'b1;
                end
                state_d = IDLE;
                if (!kill_now) begin
                    ex2wb_d = complete(instr_q.instr, instr_q.id, instr_q.rs1, instr_q.rd,
                                       dotp_acc(instr_q.op_c, prod_q[0], prod_q[1],
                                                prod_q[2], prod_q[3]));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and externally visible state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_req_q   <= '0;
            killed_q    <= 1'b0;
            ex2wb_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_req_q   <= mem_req_d;
            killed_q    <= killed_d;
            ex2wb_q     <= ex2wb_d;
        end
    end

    // Instruction register and products; only read after an accept has loaded them.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            instr_q.instr <= id2ex_i.instr;
            instr_q.id    <= id2ex_i.id;
            instr_q.rs1   <= id2ex_i.rs1;
            instr_q.rd    <= id2ex_i.rd;
            instr_q.op_a  <= id2ex_i.op_a;
            instr_q.op_c  <= id2ex_i.op_c;
            instr_q.imm   <= id2ex_i.imm;
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Directed and randomized bench for fir_xifu_ex against an arithmetic reference model.
module tb_fir_xifu_ex;
    import cv32e40x_pkg::*;
    import fir_xifu_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    fir_xifu_id2ex_t id2ex;
    logic            ready_o;
    logic            kill_i;
    fir_xifu_ex2wb_t ex2wb_o;

    cv32e40x_if_xif xif();

    fir_xifu_ex dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .id2ex_i   (id2ex),
        .ready_o   (ready_o),
        .xif_mem_o (xif),
        .kill_i    (kill_i),
        .ex2wb_o   (ex2wb_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    fir_xifu_ex2wb_t exp_wb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: result by plain integer arithmetic, reduced modulo 2^32.
    function automatic logic [31:0] model(input logic [2:0] instr, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic [11:0] imm);
        longint s;
        byte    x;
        byte    y;
        s = 0;
        if (instr == INSTR_XFIRLW || instr == INSTR_XFIRSW) begin
            s = longint'(a) + longint'($signed(imm));
        end else if (instr == INSTR_XFIRDOTP) begin
            s = longint'($signed(c));
            for (int i = 0; i < 4; i++) begin
                x = a[8*i +: 8];
                y = b[8*i +: 8];
                s = s + longint'(x) * longint'(y);
            end
        end
        return s[31:0];
    endfunction

    task automatic chk_wb(input string tag, input logic exp_valid);
        chk({tag, ":wb_valid"},  64'(ex2wb_o.valid),  64'(exp_valid));
        chk({tag, ":wb_result"}, 64'(ex2wb_o.result), 64'(exp_wb.result));
        chk({tag, ":wb_id"},     64'(ex2wb_o.id),     64'(exp_wb.id));
        chk({tag, ":wb_fields"}, 64'({ex2wb_o.instr, ex2wb_o.rs1, ex2wb_o.rd}),
            64'({exp_wb.instr, exp_wb.rs1, exp_wb.rd}));
    endtask

    // kill_at: -1 none, -2 kill pulsed in the (IDLE) accept cycle, k>=0 kill in busy cycle k.
    task automatic do_op(input string tag, input logic [2:0] instr, input logic [3:0] id,
                         input logic [4:0] rs1, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [11:0] imm, input int stall, input int kill_at);
        logic        is_mem;
        logic        killed;
        logic [31:0] exp_res;
        is_mem  = (instr == INSTR_XFIRLW) || (instr == INSTR_XFIRSW);
        killed  = 1'b0;
        exp_res = model(instr, a, b, c, imm);
        chk({tag, ":ready_idle"}, 64'(ready_o), 64'(1));
        id2ex.valid = 1'b1;
        id2ex.instr = instr;
        id2ex.id    = id;
        id2ex.rs1   = rs1;
        id2ex.rd    = rd;
        id2ex.op_a  = a;
        id2ex.op_b  = b;
        id2ex.op_c  = c;
        id2ex.imm   = imm;
        kill_i        = (kill_at == -2);
        xif.mem_ready = 1'($urandom);
        @(posedge clk_i); #1;
        id2ex.valid = 1'b0;
        kill_i      = 1'b0;
        if (is_mem) begin
            for (int w = 0; w <= stall; w++) begin
                chk({tag, ":mem_valid"}, 64'(xif.mem_valid), 64'(1));
                chk({tag, ":addr"},      64'(xif.mem_req.addr), 64'(a));
                chk({tag, ":we"},        64'(xif.mem_req.we), 64'(instr == INSTR_XFIRSW));
                chk({tag, ":wdata"},     64'(xif.mem_req.wdata),
                    64'((instr == INSTR_XFIRSW) ? b : 32'h0));
                chk({tag, ":req_id"},    64'(xif.mem_req.id), 64'(id));
                chk({tag, ":req_attr"},
                    64'({xif.mem_req.size, xif.mem_req.be, xif.mem_req.mode,
                         xif.mem_req.last, xif.mem_req.spec}),
                    64'({3'b010, 4'hF, 2'b11, 1'b1, 1'b0}));
                chk({tag, ":ready_busy"}, 64'(ready_o), 64'(0));
                chk({tag, ":no_early_wb"}, 64'(ex2wb_o.valid), 64'(0));
                kill_i = (w == kill_at);
                if (w == kill_at) killed = 1'b1;
                xif.mem_ready = (w == stall);
                @(posedge clk_i); #1;
                kill_i = 1'b0;
            end
            xif.mem_ready = 1'b0;
            chk({tag, ":mem_valid_drop"}, 64'(xif.mem_valid), 64'(0));
        end else if (instr == INSTR_XFIRDOTP) begin
            chk({tag, ":ready_busy"}, 64'(ready_o), 64'(0));
            chk({tag, ":no_early_wb"}, 64'(ex2wb_o.valid), 64'(0));
            chk({tag, ":no_req"}, 64'(xif.mem_valid), 64'(0));
            kill_i = (kill_at == 0);
            if (kill_at == 0) killed = 1'b1;
            @(posedge clk_i); #1;
            kill_i = 1'b0;
        end else begin
            chk({tag, ":no_req"}, 64'(xif.mem_valid), 64'(0));
        end
        if (!killed) begin
            exp_wb.instr  = instr;
            exp_wb.id     = id;
            exp_wb.rs1    = rs1;
            exp_wb.rd     = rd;
            exp_wb.result = exp_res;
        end
        chk_wb(tag, !killed);
    endtask

    initial begin
        int          sel;
        int          stall;
        int          kill_at;
        logic [2:0]  instr;

        rst_ni        = 1'b0;
        kill_i        = 1'b0;
        xif.mem_ready = 1'b0;
        id2ex         = '0;
        exp_wb        = '0;

        // Reset state
        @(posedge clk_i); #1;
        chk("rst:ready", 64'(ready_o), 64'(1));
        chk("rst:mem_valid", 64'(xif.mem_valid), 64'(0));
        chk("rst:req_addr", 64'(xif.mem_req.addr), 64'(0));
        chk("rst:req_wdata", 64'(xif.mem_req.wdata), 64'(0));
        chk("rst:req_misc",
            64'({xif.mem_req.id, xif.mem_req.mode, xif.mem_req.we, xif.mem_req.size,
                 xif.mem_req.be, xif.mem_req.attr, xif.mem_req.last, xif.mem_req.spec}),
            64'(0));
        chk("rst:ex2wb", 64'(ex2wb_o), 64'(0));
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // LW with mem_ready already high, then the completion pulse must end
        do_op("lw", INSTR_XFIRLW, 4'd3, 5'd1, 5'd2, 32'h1000, 32'h0, 32'h0, 12'd4, 0, -1);
        chk("lw:result_const", 64'(ex2wb_o.result), 64'h1004);
        @(posedge clk_i); #1;
        chk("lw:pulse_end", 64'(ex2wb_o.valid), 64'(0));
        chk("lw:result_held", 64'(ex2wb_o.result), 64'h1004);

        // SW held off by three cycles of backpressure
        do_op("sw", INSTR_XFIRSW, 4'd5, 5'd6, 5'd7, 32'h2000, 32'hDEADBEEF, 32'h0, 12'hFFC, 3, -1);
        chk("sw:result_const", 64'(ex2wb_o.result), 64'h1FFC);

        // DOTP: 10 + 127*127 + (-128)*127 + (-1)*2 + 1*2 = -117
        do_op("dotp", INSTR_XFIRDOTP, 4'd9, 5'd3, 5'd1, 32'h7F80FF01, 32'h7F7F0202, 32'd10, 12'h0, 0, -1);
        chk("dotp:result_const", 64'(ex2wb_o.result), 64'hFFFFFF8B);

        // Address wraps modulo 2^32
        do_op("wrap", INSTR_XFIRLW, 4'd1, 5'd2, 5'd3, 32'hFFFFFFFC, 32'h0, 32'h0, 12'd8, 0, -1);
        chk("wrap:result_const", 64'(ex2wb_o.result), 64'h4);

        // Kill while the request waits: request held, no completion, result kept
        do_op("kill_mem", INSTR_XFIRLW, 4'd12, 5'd4, 5'd5, 32'h3000, 32'h0, 32'h0, 12'd16, 3, 1);
        chk("kill_mem:result_kept", 64'(ex2wb_o.result), 64'h4);

        // Kill in the DOTP cycle suppresses completion
        do_op("kill_dotp", INSTR_XFIRDOTP, 4'd13, 5'd4, 5'd5, 32'h01010101, 32'h01010101, 32'd1, 12'h0, 0, 0);

        // Unknown opcode completes next cycle with zero, kill in IDLE ignored
        do_op("other", 3'd5, 4'd14, 5'd8, 5'd9, 32'h12345678, 32'h9ABCDEF0, 32'h5, 12'h7, 0, -2);
        chk("other:result_const", 64'(ex2wb_o.result), 64'h0);

        // Asynchronous reset in the DOTP cycle
        id2ex.valid = 1'b1;
        id2ex.instr = INSTR_XFIRDOTP;
        id2ex.id    = 4'd6;
        id2ex.op_a  = 32'h01020304;
        id2ex.op_b  = 32'h05060708;
        id2ex.op_c  = 32'h0;
        @(posedge clk_i); #1;
        id2ex.valid = 1'b0;
        chk("arst:busy", 64'(ready_o), 64'(0));
        rst_ni = 1'b0;
        #1;
        chk("arst:ready", 64'(ready_o), 64'(1));
        chk("arst:ex2wb", 64'(ex2wb_o), 64'(0));
        chk("arst:mem_valid", 64'(xif.mem_valid), 64'(0));
        exp_wb = '0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        do_op("lw_after_rst", INSTR_XFIRLW, 4'd3, 5'd1, 5'd2, 32'h1000, 32'h0, 32'h0, 12'd4, 0, -1);
        chk("lw_after_rst:result_const", 64'(ex2wb_o.result), 64'h1004);

        // Randomized back-to-back traffic
        for (int n = 0; n < 60; n++) begin
            sel   = int'($urandom_range(0, 3));
            stall = int'($urandom_range(0, 3));
            case (sel)
                0: instr = INSTR_XFIRLW;
                1: instr = INSTR_XFIRSW;
                2: instr = INSTR_XFIRDOTP;
                default: begin
                    instr = 3'($urandom_range(3, 7));
                    if (instr == 3'd3) instr = INSTR_INVALID;
                end
            endcase
            kill_at = -1;
            if ($urandom_range(0, 4) == 0) begin
                if (sel <= 1) kill_at = int'($urandom_range(0, stall));
                else if (sel == 2) kill_at = 0;
                else kill_at = -2;
            end
            do_op("rand", instr, 4'($urandom), 5'($urandom), 5'($urandom),
                  $urandom, $urandom, $urandom, 12'($urandom), stall, kill_at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
